clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Sequencer between the button debouncer and `clock_register`. It turns the debounced set-hours and set-minutes buttons into the `i_set_hours`, `i_set_minutes` and `i_set_stb` controls of the clock register. The sequence is a single step on press, slow auto-repeat while held, automatic acceleration to fast repeat, and a seconds-clear mode when both buttons are held. It replaces the ad-hoc `fast_set ? fast_stb : slow_stb` mux at top level and consumes the strobes from `clk_gen`.

## Interface
- `ACCEL_COUNT`, default 4: slow-repeat pulses emitted before switching to fast repeat. Legal range 1..15.
- `i_clk` input 1: system clock. One clock domain; all logic is on its rising edge.
- `i_reset_n` input 1: asynchronous, active-low reset.
- `i_slow_set_stb` input 1: one-cycle slow-repeat strobe from `clk_gen`.
- `i_fast_set_stb` input 1: one-cycle fast-repeat strobe from `clk_gen`.
- `i_fast_set` input 1: debounced force-fast level. When high, repeat uses the fast strobe from the first repeat.
- `i_set_hours` input 1: debounced hours button level.
- `i_set_minutes` input 1: debounced minutes button level.
- `o_set_hours` output 1: to `clock_register` `i_set_hours`.
- `o_set_minutes` output 1: to `clock_register` `i_set_minutes`.
- `o_set_stb` output 1: one-cycle increment pulse to `clock_register` `i_set_stb`.
- `o_fast_active` output 1: high while in `HOLD_FAST`.
- `o_set_active` output 1: high in any state other than `IDLE` (for display blanking or blinking).

## Operation
- FSM states: `IDLE`, `STEP`, `HOLD_SLOW`, `HOLD_FAST`, `CLEAR`.
- Internal registers: `sel_hours` (field latch), `accel_cnt` (4-bit). Every output is registered (Moore form).
- **IDLE**: all outputs 0.
  - Both buttons high → `CLEAR`.
  - Exactly one button high → `STEP`; `sel_hours` ← `i_set_hours`.
  - Strobes are ignored.
- **STEP**: lasts exactly one cycle.
  - Selected field output = 1, `o_set_stb` = 1.
  - `accel_cnt` ← 0.
  - Always → `HOLD_SLOW`, regardless of button state.
- **HOLD_SLOW**: selected field output = 1.
  - Repeat source = `i_fast_set ? i_fast_set_stb : i_slow_set_stb`.
  - Each repeat-source strobe gives `o_set_stb` = 1 on the next cycle and increments `accel_cnt` (saturating at 15).
  - When the incremented count equals `ACCEL_COUNT` → `HOLD_FAST`.
- **HOLD_FAST**: selected field output = 1. Each `i_fast_set_stb` gives `o_set_stb` = 1 on the next cycle.
- Exits from both HOLD states, in priority order:
  1. Selected button low → `IDLE`, with no pulse for a strobe arriving that same cycle.
  2. Other button high → `CLEAR`, with no pulse.
- **CLEAR**: `o_set_hours` = `o_set_minutes` = 1, `o_set_stb` = 0. `clock_register` zeroes seconds while both field inputs are high.
  - Stays in `CLEAR` until both buttons are low, then → `IDLE`.
  - Releasing only one button never causes a step.
- Only one field output is high outside `CLEAR`.
- `sel_hours` is only updated in `IDLE`.

## Timing
- Reset (async assert): state `IDLE`, `sel_hours` = 0, `accel_cnt` = 0, all outputs 0 immediately. No pulse is emitted on reset release.
- Reset asserted mid-sequence drops every output in the same instant. After release the block is in `IDLE` and needs a fresh button-low-to-high evaluation in `IDLE`; a held button steps again.
- Press-to-output latency:
  - Button high at edge N → `STEP` outputs visible after edge N+1.
  - First `o_set_stb` is high for exactly cycle N+1 to N+2.
- Strobe-to-pulse latency: 1 cycle. `o_set_stb` width is always exactly 1 cycle. No back-to-back pulses, because source strobes are at least 2 cycles apart.
- Release latency: button low at edge N → field output low after edge N+1.
- `o_fast_active` rises with the cycle following the `ACCEL_COUNT`-th repeat pulse, and falls on exit from `HOLD_FAST`.
- Pulses per hold with `ACCEL_COUNT` = A: 1 (`STEP`) + A slow pulses, then fast pulses until release.
- Simultaneous slow and fast strobe: only one pulse, from the selected source.

## Test plan
1. **Tap.** Hours high for 5 cycles, released before any slow strobe → exactly one `o_set_stb` with `o_set_hours` = 1; `clock_register` hours 10→11; `o_set_active` back to 0 two cycles after release.
2. **Acceleration** (A = 4, `i_fast_set` = 0). Hold minutes across 8 slow strobes:
   - 1 step plus 4 pulses aligned one cycle after slow strobes.
   - `o_fast_active` = 1 after the 4th.
   - Further pulses track `i_fast_set_stb`.
   - Release → `o_fast_active` = 0.
3. **Force fast.** `i_fast_set` = 1, hold hours from 23 for 2 fast strobes → step plus 2 pulses; hours 23→0→1→2 (wrap).
4. **Clear.** Hold both buttons → no `o_set_stb`, both field outputs 1, seconds reach 0. Release hours only → still `CLEAR`, no step. Release minutes → `IDLE` next cycle.
5. **Release race.** Release the button on the same edge as a slow strobe → no pulse. Press the other button on the same edge as a strobe in `HOLD_SLOW` → `CLEAR`, no pulse.
6. **Reset mid-`HOLD_FAST`.** Assert `i_reset_n` low between clock edges → all outputs 0 before the next edge. Release reset with a button held → `STEP` pulse two cycles after the release edge.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: sequences debounced set buttons into step, auto-repeat, acceleration and seconds-clear
module clock_set_ctrl #(
  parameter int ACCEL_COUNT = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_slow_set_stb,
  input  logic i_fast_set_stb,
  input  logic i_fast_set,
  input  logic i_set_hours,
  input  logic i_set_minutes,
  output logic o_set_hours,
  output logic o_set_minutes,
  output logic o_set_stb,
  output logic o_fast_active,
  output logic o_set_active
);
  typedef enum logic [2:0] {IDLE, STEP, HOLD_SLOW, HOLD_FAST, CLEAR} state_t;
  state_t state, state_nxt;
  logic sel_hours;
  logic [3:0] accel_cnt, cnt_inc;
  logic holding, sel_btn, other_btn, src_stb, rep;
  assign holding   = state == HOLD_SLOW || state == HOLD_FAST;
  assign sel_btn   = sel_hours ? i_set_hours : i_set_minutes;
  assign other_btn = sel_hours ? i_set_minutes : i_set_hours;
  assign src_stb   = (state == HOLD_FAST || i_fast_set) ? i_fast_set_stb : i_slow_set_stb;
  assign rep       = holding && sel_btn && !other_btn && src_stb;
  assign cnt_inc   = accel_cnt == 4'd15 ? 4'd15 : accel_cnt + 4'd1;
  // state register
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state <= IDLE;
    else state <= state_nxt;
  // next state; release of the selected button wins over the other button being pressed
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = (i_set_hours && i_set_minutes) ? CLEAR :
                             (i_set_hours || i_set_minutes) ? STEP : IDLE;
      STEP:      state_nxt = HOLD_SLOW;
      HOLD_SLOW: state_nxt = !sel_btn ? IDLE : other_btn ? CLEAR :
                             (src_stb && cnt_inc == 4'(ACCEL_COUNT)) ? HOLD_FAST : HOLD_SLOW;
      HOLD_FAST: state_nxt = !sel_btn ? IDLE : other_btn ? CLEAR : HOLD_FAST;
      CLEAR:     state_nxt = (!i_set_hours && !i_set_minutes) ? IDLE : CLEAR;
      default:   state_nxt = IDLE;
    endcase
  end
  // field latch and acceleration counter
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      sel_hours <= 1'b0;
      accel_cnt <= 4'd0;
    end else begin
      if (state == IDLE && state_nxt == STEP) sel_hours <= i_set_hours;
      if (state == STEP) accel_cnt <= 4'd0;
      else if (state == HOLD_SLOW && rep) accel_cnt <= cnt_inc;
    end
  // registered outputs; a repeat pulse follows its source strobe by one cycle
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      o_set_hours   <= 1'b0;
      o_set_minutes <= 1'b0;
      o_set_stb     <= 1'b0;
      o_fast_active <= 1'b0;
      o_set_active  <= 1'b0;
    end else begin
      o_set_hours   <= state == CLEAR || ((state == STEP || holding) && sel_hours);
      o_set_minutes <= state == CLEAR || ((state == STEP || holding) && !sel_hours);
      o_set_stb     <= state == STEP || rep;
      o_fast_active <= state == HOLD_FAST;
      o_set_active  <= state != IDLE;
    end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scoreboard bench for clock_set_ctrl
module tb_clock_set_ctrl;
  logic i_clk = 0, i_reset_n = 0;
  logic i_slow_set_stb = 0, i_fast_set_stb = 0, i_fast_set = 0, i_set_hours = 0, i_set_minutes = 0;
  logic o_set_hours, o_set_minutes, o_set_stb, o_fast_active, o_set_active;
  int checks = 0, failures = 0, cyc = 0, n_slow;
  typedef struct {int c; logic h; logic m;} pulse_t;
  pulse_t exp_q[$];
  pulse_t mon_e;

  clock_set_ctrl #(.ACCEL_COUNT(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_slow_set_stb(i_slow_set_stb),
    .i_fast_set_stb(i_fast_set_stb), .i_fast_set(i_fast_set), .i_set_hours(i_set_hours),
    .i_set_minutes(i_set_minutes), .o_set_hours(o_set_hours), .o_set_minutes(o_set_minutes),
    .o_set_stb(o_set_stb), .o_fast_active(o_fast_active), .o_set_active(o_set_active));

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk)
    if (i_reset_n && o_set_stb) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d got o_set_stb=1 want 0", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.c != cyc || o_set_hours !== mon_e.h || o_set_minutes !== mon_e.m) begin
          failures++;
          $display("FAIL pulse got cyc=%0d h=%b m=%b want cyc=%0d h=%b m=%b",
                   cyc, o_set_hours, o_set_minutes, mon_e.c, mon_e.h, mon_e.m);
        end
      end
    end

  task automatic drive(input logic h, input logic m, input logic fs, input logic sl, input logic fa);
    i_set_hours = h; i_set_minutes = m; i_fast_set = fs; i_slow_set_stb = sl; i_fast_set_stb = fa;
    @(negedge i_clk);
  endtask

  task automatic push(input int c, input logic h, input logic m);
    exp_q.push_back('{c: c, h: h, m: m});
  endtask

  task automatic test_reset;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_set_hours, o_set_minutes, o_set_stb, o_fast_active, o_set_active} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=00000",
               {o_set_hours, o_set_minutes, o_set_stb, o_fast_active, o_set_active});
    end
    i_reset_n = 1;
    repeat (3) drive(0, 0, 0, 0, 0);
    checks++;
    if (o_set_active !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_active got=%b want=0", o_set_active);
    end
  endtask

  task automatic test_tap;
    push(cyc + 2, 1, 0);
    repeat (5) drive(1, 0, 0, 0, 0);
    checks++;
    if (o_set_hours !== 1'b1 || o_set_minutes !== 1'b0 || o_set_active !== 1'b1) begin
      failures++;
      $display("FAIL tap_hold got h=%b m=%b act=%b want 1 0 1", o_set_hours, o_set_minutes, o_set_active);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (o_set_active !== 1'b1) begin
      failures++;
      $display("FAIL tap_release_lag got=%b want=1", o_set_active);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (o_set_active !== 1'b0 || o_set_hours !== 1'b0) begin
      failures++;
      $display("FAIL tap_release got act=%b h=%b want 0 0", o_set_active, o_set_hours);
    end
    repeat (3) drive(0, 0, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL tap_missing got=%0d pending want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_accel;
    n_slow = 0;
    push(cyc + 2, 0, 1);
    repeat (3) drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      if (n_slow >= 4) push(cyc + 1, 0, 1);
      drive(0, 1, 0, 0, 1);
      drive(0, 1, 0, 0, 0);
      drive(0, 1, 0, 0, 0);
      checks++;
      if (o_fast_active !== (n_slow >= 4)) begin
        failures++;
        $display("FAIL accel_fast_active iter=%0d got=%b want=%b", k, o_fast_active, n_slow >= 4);
      end
      if (n_slow < 4) begin
        push(cyc + 1, 0, 1);
        n_slow++;
      end
      drive(0, 1, 0, 1, 0);
      drive(0, 1, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    checks++;
    if (o_fast_active !== 1'b0 || o_set_minutes !== 1'b0) begin
      failures++;
      $display("FAIL accel_release got fast=%b m=%b want 0 0", o_fast_active, o_set_minutes);
    end
    repeat (2) drive(0, 0, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL accel_missing got=%0d pending want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_force_fast;
    push(cyc + 2, 1, 0);
    repeat (3) drive(1, 0, 1, 0, 0);
    push(cyc + 1, 1, 0);
    drive(1, 0, 1, 0, 1);
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 1, 1, 0);
    drive(1, 0, 1, 0, 0);
    push(cyc + 1, 1, 0);
    drive(1, 0, 1, 0, 1);
    drive(1, 0, 1, 0, 0);
    push(cyc + 1, 1, 0);
    drive(1, 0, 1, 1, 1);
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 0);
    checks++;
    if (o_fast_active !== 1'b0 || o_set_hours !== 1'b1) begin
      failures++;
      $display("FAIL force_fast_state got fast=%b h=%b want 0 1", o_fast_active, o_set_hours);
    end
    repeat (3) drive(0, 0, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL force_fast_missing got=%0d pending want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_clear;
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 0);
    drive(1, 1, 0, 0, 1);
    checks++;
    if (o_set_hours !== 1'b1 || o_set_minutes !== 1'b1 || o_set_active !== 1'b1 || o_fast_active !== 1'b0) begin
      failures++;
      $display("FAIL clear_fields got h=%b m=%b act=%b fast=%b want 1 1 1 0",
               o_set_hours, o_set_minutes, o_set_active, o_fast_active);
    end
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 0);
    drive(0, 1, 0, 0, 0);
    checks++;
    if (o_set_hours !== 1'b1 || o_set_minutes !== 1'b1) begin
      failures++;
      $display("FAIL clear_one_released got h=%b m=%b want 1 1", o_set_hours, o_set_minutes);
    end
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    checks++;
    if (o_set_active !== 1'b0 || o_set_hours !== 1'b0 || o_set_minutes !== 1'b0) begin
      failures++;
      $display("FAIL clear_exit got act=%b h=%b m=%b want 0 0 0", o_set_active, o_set_hours, o_set_minutes);
    end
    repeat (2) drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_release_race;
    push(cyc + 2, 1, 0);
    repeat (4) drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    checks++;
    if (o_set_active !== 1'b0) begin
      failures++;
      $display("FAIL race_release got act=%b want 0", o_set_active);
    end
    push(cyc + 2, 0, 1);
    repeat (4) drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 0);
    drive(1, 1, 0, 0, 0);
    checks++;
    if (o_set_hours !== 1'b1 || o_set_minutes !== 1'b1) begin
      failures++;
      $display("FAIL race_to_clear got h=%b m=%b want 1 1", o_set_hours, o_set_minutes);
    end
    repeat (3) drive(0, 0, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL race_missing got=%0d pending want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    push(cyc + 2, 1, 0);
    repeat (3) drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      push(cyc + 1, 1, 0);
      drive(1, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
    end
    drive(1, 0, 0, 0, 0);
    checks++;
    if (o_fast_active !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_fast got=%b want 1", o_fast_active);
    end
    #2 i_reset_n = 0;
    #1;
    checks++;
    if ({o_set_hours, o_set_minutes, o_set_stb, o_fast_active, o_set_active} !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_async got=%b want=00000",
               {o_set_hours, o_set_minutes, o_set_stb, o_fast_active, o_set_active});
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1;
    push(cyc + 2, 1, 0);
    repeat (3) drive(1, 0, 0, 0, 0);
    checks++;
    if (o_set_hours !== 1'b1 || o_fast_active !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_restep got h=%b fast=%b want 1 0", o_set_hours, o_fast_active);
    end
    repeat (3) drive(0, 0, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_missing got=%0d pending want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset;
    test_tap;
    test_accel;
    test_force_fast;
    test_clear;
    test_release_race;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
